// File: rtl/wdt_kick_supervisor_pkg.sv
// wdt_sup_pkg: shared types and constants for the watchdog kick supervisor.
// Optional feature macro used by the design: WDT_SUP_READBACK_EN.
package wdt_sup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_VERIFY = 3'd2,
    ST_ARMED  = 3'd3,
    ST_KICK   = 3'd4,
    ST_STARVE = 3'd5,
    ST_FAULT  = 3'd6,
    ST_CLEAR  = 3'd7
  } state_t;

  // Watchdog slave register map
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  // Control word: bit0 irq enable, bit2 start
  localparam logic [15:0] CTRL_START_IRQ = 16'h0005;
  // Any write to PERIODL forces a reload of the watchdog counter
  localparam logic [15:0] KICK_DATA      = 16'h0000;
  // Writing STATUS clears the timeout flag
  localparam logic [15:0] STATUS_CLEAR   = 16'h0000;
  // STATUS bit reporting that the watchdog counter is running
  localparam int unsigned STATUS_RUN_BIT = 1;

  localparam logic [19:0] WDT_DEFAULT_PERIOD = 20'hF423F;

  // Width of a counter that must hold values 0..max_val (never below 1 bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // States that perform exactly one access on the watchdog bus
  function automatic logic is_access(input state_t s);
    return (s == ST_CFG) || (s == ST_VERIFY) || (s == ST_KICK) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/wdt_kick_supervisor_if.sv
// wdt_kick_supervisor_if: watchdog slave bus (16-bit registers, no wait states).
// Master side is the supervisor; slave side is the watchdog peripheral.
interface wdt_kick_supervisor_if;

  logic [2:0]  wdt_address;
  logic        wdt_chipselect;
  logic        wdt_write_n;
  logic [15:0] wdt_writedata;
  logic [15:0] wdt_readdata;
  logic        wdt_irq;

  modport master (
    output wdt_address,
    output wdt_chipselect,
    output wdt_write_n,
    output wdt_writedata,
    input  wdt_readdata,
    input  wdt_irq
  );

  modport slave (
    input  wdt_address,
    input  wdt_chipselect,
    input  wdt_write_n,
    input  wdt_writedata,
    output wdt_readdata,
    output wdt_irq
  );

endinterface

// File: rtl/wdt_kick_supervisor_hb_collect.sv
// wdt_sup_hb_collect: heartbeat bookkeeping for the kick supervisor.
// Tracks which requesters checked in during the current window, the sticky
// mask of requesters that missed a window, and the window/gap counters.
module wdt_sup_hb_collect
  import wdt_sup_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned HB_TIMEOUT = 800000,
  parameter int unsigned MIN_GAP    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  state_t           state,
  input  logic [N_REQ-1:0] hb,
  input  logic             starve_entry,
  output logic             all_seen,
  output logic             gap_met,
  output logic             window_done,
  output logic [N_REQ-1:0] missing
);

  localparam int unsigned WIN_W = cnt_width(HB_TIMEOUT);
  localparam int unsigned GAP_W = cnt_width(MIN_GAP);
  localparam logic [WIN_W-1:0] WIN_LIMIT = WIN_W'(HB_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MIN_GAP);

  logic [N_REQ-1:0] seen_q;
  logic [WIN_W-1:0] window_q;
  logic [GAP_W-1:0] gap_q;

  // Accumulate heartbeats in ARMED; a pulse during KICK seeds the next window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q <= '0;
    end else begin
      case (state)
        ST_ARMED: seen_q <= seen_q | hb;
        ST_KICK:  seen_q <= hb;
        default:  seen_q <= '0;
      endcase
    end
  end

  // Window and gap counters run only in ARMED, so they restart at zero on every entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q <= '0;
      gap_q    <= '0;
    end else if (state == ST_ARMED) begin
      if (window_q != WIN_LIMIT) window_q <= window_q + WIN_W'(1);
      if (gap_q != GAP_LIMIT)    gap_q    <= gap_q + GAP_W'(1);
    end else begin
      window_q <= '0;
      gap_q    <= '0;
    end
  end

  // Sticky record of absent requesters, wiped only by the CLEAR recovery step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      missing <= '0;
    end else if (state == ST_CLEAR) begin
      missing <= '0;
    end else if (starve_entry) begin
      missing <= missing | ~seen_q;
    end
  end

  assign all_seen    = &seen_q;
  assign gap_met     = (gap_q >= GAP_LIMIT);
  assign window_done = (window_q == WIN_LIMIT);

endmodule

// File: rtl/wdt_kick_supervisor.sv
// wdt_kick_supervisor: bus master that configures and services the watchdog
// on behalf of N_REQ heartbeat requesters. The watchdog is kicked only after
// every requester has checked in; a missing heartbeat starves it on purpose.
// Optional readback verification of the start command: WDT_SUP_READBACK_EN.
module wdt_kick_supervisor
  import wdt_sup_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned HB_TIMEOUT = 800000,
  parameter int unsigned MIN_GAP    = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [N_REQ-1:0]            hb,
  input  logic                        clear_fault,
  wdt_kick_supervisor_if.master       wdt,
  output logic [N_REQ-1:0]            missing,
  output logic [15:0]                 kick_count,
  output logic                        fault,
  output logic                        cfg_err
);

  state_t state_q, state_d;
  logic   enable_q;
  logic   all_seen, gap_met, window_done;
  logic   starve_entry;
  logic   access_start;
  logic [2:0]  bus_addr_d;
  logic [15:0] bus_data_d;
  logic        bus_wr_d;

`ifdef WDT_SUP_READBACK_EN
  logic [1:0] vcnt_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^wdt.wdt_readdata;
`endif

  wdt_sup_hb_collect #(
    .N_REQ      (N_REQ),
    .HB_TIMEOUT (HB_TIMEOUT),
    .MIN_GAP    (MIN_GAP)
  ) u_hb_collect (
    .clk          (clk),
    .reset        (reset),
    .state        (state_q),
    .hb           (hb),
    .starve_entry (starve_entry),
    .all_seen     (all_seen),
    .gap_met      (gap_met),
    .window_done  (window_done),
    .missing      (missing)
  );

  // State register and enable edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable;
    end
  end

  // Next-state logic; dropping enable aborts everything except a latched FAULT
  always_comb begin
    state_d = state_q;
    if (!enable && (state_q != ST_FAULT)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (!enable_q) state_d = ST_CFG;
        ST_CFG: begin
`ifdef WDT_SUP_READBACK_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_ARMED;
`endif
        end
        ST_VERIFY: begin
`ifdef WDT_SUP_READBACK_EN
          if (vcnt_q == 2'd2)
            state_d = wdt.wdt_readdata[STATUS_RUN_BIT] ? ST_ARMED : ST_FAULT;
`else
          state_d = ST_IDLE;
`endif
        end
        ST_ARMED: begin
          if (wdt.wdt_irq)                  state_d = ST_FAULT;
          else if (all_seen && gap_met)     state_d = ST_KICK;
          else if (window_done && !all_seen) state_d = ST_STARVE;
        end
        ST_KICK:   state_d = wdt.wdt_irq ? ST_FAULT : ST_ARMED;
        ST_STARVE: begin
          if (clear_fault)      state_d = ST_CLEAR;
          else if (wdt.wdt_irq) state_d = ST_FAULT;
        end
        ST_FAULT:  if (clear_fault) state_d = ST_CLEAR;
        ST_CLEAR:  state_d = ST_CFG;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign starve_entry = (state_q == ST_ARMED) && (state_d == ST_STARVE);

  // Bus command for the coming cycle; only the first cycle of an access state drives the bus
  always_comb begin
    access_start = is_access(state_d) && (state_d != state_q);
    bus_addr_d   = '0;
    bus_data_d   = '0;
    bus_wr_d     = 1'b0;
    if (access_start) begin
      case (state_d)
        ST_CFG: begin
          bus_addr_d = ADDR_CONTROL;
          bus_data_d = CTRL_START_IRQ;
          bus_wr_d   = 1'b1;
        end
        ST_VERIFY: bus_addr_d = ADDR_STATUS;
        ST_KICK: begin
          bus_addr_d = ADDR_PERIODL;
          bus_data_d = KICK_DATA;
          bus_wr_d   = 1'b1;
        end
        ST_CLEAR: begin
          bus_addr_d = ADDR_STATUS;
          bus_data_d = STATUS_CLEAR;
          bus_wr_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered bus outputs, decoded from the next state so the access lines up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt.wdt_address    <= '0;
      wdt.wdt_chipselect <= 1'b0;
      wdt.wdt_write_n    <= 1'b1;
      wdt.wdt_writedata  <= '0;
    end else begin
      wdt.wdt_address    <= bus_addr_d;
      wdt.wdt_chipselect <= access_start;
      wdt.wdt_write_n    <= ~bus_wr_d;
      wdt.wdt_writedata  <= bus_data_d;
    end
  end

  // Kick counter (wraps) and fault flag, which trails the STARVE/FAULT state by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kick_count <= '0;
      fault      <= 1'b0;
    end else begin
      if (state_q == ST_KICK) kick_count <= kick_count + 16'd1;
      fault <= (state_q == ST_STARVE) || (state_q == ST_FAULT);
    end
  end

`ifdef WDT_SUP_READBACK_EN
  // Readback timing: read in VERIFY cycle 0, status sampled in VERIFY cycle 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcnt_q <= '0;
    end else if (state_q == ST_VERIFY) begin
      vcnt_q <= vcnt_q + 2'd1;
    end else begin
      vcnt_q <= '0;
    end
  end

  // Sticky configuration error, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else if ((state_q == ST_VERIFY) && (state_d == ST_FAULT)) begin
      cfg_err <= 1'b1;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_wdt_kick_supervisor.sv
// Testbench for wdt_kick_supervisor with N_REQ=2, HB_TIMEOUT=100, MIN_GAP=10.
// Honors WDT_SUP_READBACK_EN when the design is built with it.
module tb_wdt_kick_supervisor;

  localparam int unsigned N_REQ      = 2;
  localparam int unsigned HB_TIMEOUT = 100;
  localparam int unsigned MIN_GAP    = 10;
`ifdef WDT_SUP_READBACK_EN
  localparam int unsigned VLAT = 3;
`else
  localparam int unsigned VLAT = 0;
`endif

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [N_REQ-1:0] hb;
  logic             clear_fault;
  logic [N_REQ-1:0] missing;
  logic [15:0]      kick_count;
  logic             fault;
  logic             cfg_err;

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        exp_q[$];

  wdt_kick_supervisor_if bus();

  wdt_kick_supervisor #(
    .N_REQ      (N_REQ),
    .HB_TIMEOUT (HB_TIMEOUT),
    .MIN_GAP    (MIN_GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .hb          (hb),
    .clear_fault (clear_fault),
    .wdt         (bus),
    .missing     (missing),
    .kick_count  (kick_count),
    .fault       (fault),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [2:0] a, input logic w, input logic [15:0] d,
                          input int unsigned c);
    exp_t e;
    e.addr = a;
    e.wr   = w;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Configuration write at cycle c (plus readback when enabled); returns first ARMED cycle
  task automatic expect_cfg(input int unsigned c, output int unsigned armed);
    push_exp(3'd1, 1'b1, 16'h0005, c);
    if (VLAT != 0) push_exp(3'd0, 1'b0, 16'h0000, c + 1);
    armed = c + 1 + VLAT;
  endtask

  task automatic wait_cycle(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_hb(input int unsigned t, input logic [N_REQ-1:0] v);
    wait_cycle(t);
    hb = v;
    @(negedge clk);
    hb = '0;
  endtask

  // Monitor: every bus access must match the head of the expected queue
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.wdt_chipselect) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: got addr=%0d write_n=%0b data=%h cycle=%0d, required no access",
                   bus.wdt_address, bus.wdt_write_n, bus.wdt_writedata, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ((bus.wdt_address !== e.addr) || (bus.wdt_write_n !== !e.wr) ||
              (e.wr && (bus.wdt_writedata !== e.data)) || (cyc != e.cyc)) begin
            errors++;
            $display("FAIL bus_access: got addr=%0d write_n=%0b data=%h cycle=%0d, required addr=%0d write_n=%0b data=%h cycle=%0d",
                     bus.wdt_address, bus.wdt_write_n, bus.wdt_writedata, cyc,
                     e.addr, !e.wr, e.data, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int unsigned e0, a0, a1, a2, a3, c0, c1;
    reset           = 1'b1;
    enable          = 1'b0;
    hb              = '0;
    clear_fault     = 1'b0;
    bus.wdt_irq     = 1'b0;
    bus.wdt_readdata = 16'h0002;
    repeat (3) @(negedge clk);

    chk("rst_chipselect", 32'(bus.wdt_chipselect), 32'd0);
    chk("rst_write_n",    32'(bus.wdt_write_n),    32'd1);
    chk("rst_address",    32'(bus.wdt_address),    32'd0);
    chk("rst_writedata",  32'(bus.wdt_writedata),  32'd0);
    chk("rst_missing",    32'(missing),            32'd0);
    chk("rst_kick_count", 32'(kick_count),         32'd0);
    chk("rst_fault",      32'(fault),              32'd0);
    chk("rst_cfg_err",    32'(cfg_err),            32'd0);

    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Enable rise: one configuration write, then ARMED
    e0 = cyc;
    enable = 1'b1;
    expect_cfg(e0 + 1, a0);

    // Heartbeats at window cycles 5 and 20 -> kick write at cycle 22
    pulse_hb(a0 + 5, 2'b01);
    wait_cycle(a0 + 20);
    push_exp(3'd2, 1'b1, 16'h0000, a0 + 22);
    pulse_hb(a0 + 20, 2'b10);
    wait_cycle(a0 + 22);
    chk("kick_count_before", 32'(kick_count), 32'd0);
    // Heartbeat coincident with the KICK cycle counts toward the next window
    pulse_hb(a0 + 22, 2'b01);
    chk("kick_count_1", 32'(kick_count), 32'd1);

    // Window complete by cycle 3 -> kick held until gap reaches MIN_GAP
    a1 = a0 + 23;
    push_exp(3'd2, 1'b1, 16'h0000, a1 + 11);
    pulse_hb(a1 + 2, 2'b10);
    wait_cycle(a1 + 12);
    chk("kick_count_2", 32'(kick_count), 32'd2);

    // Only requester 0 checks in -> window expiry starves the watchdog
    a2 = a1 + 12;
    pulse_hb(a2 + 5, 2'b01);
    pulse_hb(a2 + 50, 2'b01);
    wait_cycle(a2 + 100);
    chk("missing_at_limit", 32'(missing), 32'd0);
    chk("fault_at_limit",   32'(fault),   32'd0);
    @(negedge clk);
    chk("missing_after_expiry", 32'(missing), 32'd2);
    chk("fault_lags_missing",   32'(fault),   32'd0);
    @(negedge clk);
    chk("fault_after_expiry",   32'(fault),   32'd1);
    wait_cycle(a2 + 110);
    bus.wdt_irq = 1'b1;
    @(negedge clk);
    bus.wdt_irq = 1'b0;
    wait_cycle(a2 + 115);
    chk("fault_in_fault", 32'(fault), 32'd1);

    // clear_fault: status-clear write, then reconfiguration
    c0 = cyc;
    clear_fault = 1'b1;
    push_exp(3'd0, 1'b1, 16'h0000, c0 + 1);
    expect_cfg(c0 + 2, a3);
    @(negedge clk);
    clear_fault = 1'b0;
    wait_cycle(c0 + 3);
    chk("missing_cleared", 32'(missing), 32'd0);
    chk("fault_cleared",   32'(fault),   32'd0);

    // Watchdog irq while ARMED -> FAULT; FAULT ignores enable low
    wait_cycle(a3 + 3);
    bus.wdt_irq = 1'b1;
    @(negedge clk);
    bus.wdt_irq = 1'b0;
    wait_cycle(a3 + 4);
    chk("fault_irq_lag", 32'(fault), 32'd0);
    wait_cycle(a3 + 5);
    chk("fault_irq_armed", 32'(fault), 32'd1);
    enable = 1'b0;
    wait_cycle(a3 + 9);
    chk("fault_holds_enable_low", 32'(fault), 32'd1);

    // clear_fault with enable low: status-clear write, then IDLE with no configuration
    c1 = cyc;
    clear_fault = 1'b1;
    push_exp(3'd0, 1'b1, 16'h0000, c1 + 1);
    @(negedge clk);
    clear_fault = 1'b0;
    wait_cycle(c1 + 6);
    chk("fault_idle", 32'(fault), 32'd0);
    chk("kick_count_kept", 32'(kick_count), 32'd2);

    // Reset asserted during the configuration write
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("cfg_write_cs",   32'(bus.wdt_chipselect), 32'd1);
    chk("cfg_write_wn",   32'(bus.wdt_write_n),    32'd0);
    chk("cfg_write_addr", 32'(bus.wdt_address),    32'd1);
    reset = 1'b1;
    #1;
    chk("midreset_cs",   32'(bus.wdt_chipselect), 32'd0);
    chk("midreset_wn",   32'(bus.wdt_write_n),    32'd1);
    chk("midreset_addr", 32'(bus.wdt_address),    32'd0);
    chk("midreset_data", 32'(bus.wdt_writedata),  32'd0);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_kick_count", 32'(kick_count), 32'd0);

`ifdef WDT_SUP_READBACK_EN
    // Readback reports the watchdog not running -> cfg_err and FAULT
    bus.wdt_readdata = 16'h0000;
    e0 = cyc;
    enable = 1'b1;
    expect_cfg(e0 + 1, a0);
    wait_cycle(e0 + 4);
    chk("cfg_err_before", 32'(cfg_err), 32'd0);
    wait_cycle(e0 + 5);
    chk("cfg_err_set", 32'(cfg_err), 32'd1);
    wait_cycle(e0 + 6);
    chk("cfg_err_fault", 32'(fault), 32'd1);
`else
    chk("cfg_err_tied", 32'(cfg_err), 32'd0);
`endif

    repeat (5) @(negedge clk);
    chk("pending_accesses", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
